mem_port_arbiter: RTL and testbench

- Controller sharing the single-port main-memory interface between three requesters:
  - instruction-cache refill
  - data-cache read refill
  - data-cache write-through stores
- Stores are posted into an internal write buffer.
- Produces the `stall` that freezes the program counter and pipeline while a miss is outstanding or the write buffer is full.
- Sits between the I-cache/D-cache controllers and the memory model.

---
 rtl/mem_port_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between I-cache refill, D-cache refill
// and posted write-through stores, and generates the pipeline stall.
//
// Parameters: AW address width, DW data width, WB_DEPTH store-buffer
// entries (power of two, >= 2).
// Ports:
//   clk, areset (async, active-low)
//   i_miss/i_addr          I-cache refill request
//   d_rd_miss/d_addr       D-cache refill request
//   d_wr_req/d_wr_addr/d_wr_data  store into the write buffer
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_ready/mem_rdata    memory completion strobe and read data
//   fill_data, i_fill_valid, d_fill_valid  registered refill return
//   wb_full, wb_empty      write-buffer status
//   stall                  combinational pipeline freeze
// Build option: define MEM_ARB_PERF_CNT_EN to add the stall_cycles and
// mem_xfers saturating performance counters.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int WB_DEPTH = 4
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          i_miss,
    input  logic [AW-1:0] i_addr,
    input  logic          d_rd_miss,
    input  logic [AW-1:0] d_addr,
    input  logic          d_wr_req,
    input  logic [AW-1:0] d_wr_addr,
    input  logic [DW-1:0] d_wr_data,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] fill_data,
    output logic          i_fill_valid,
    output logic          d_fill_valid,
    output logic          wb_full,
    output logic          wb_empty,
    output logic          stall
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   mem_xfers
`endif
);

    localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CW = $clog2(WB_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD_D = 2'd2,
        RD_I = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] fill_data_q, fill_data_d;
    logic          i_fill_q, i_fill_d;
    logic          d_fill_q, d_fill_d;

    logic [AW-1:0] wb_addr_q [WB_DEPTH];
    logic [DW-1:0] wb_data_q [WB_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          wb_push, wb_pop;
    logic          full, empty;
    logic          i_go, d_go;

    assign full  = (count_q == CW'(WB_DEPTH));
    assign empty = (count_q == '0);

    assign wb_push = d_wr_req & ~full;
    assign wb_pop  = (state_q == WR) & mem_ready;

    assign count_d = count_q + CW'(wb_push) - CW'(wb_pop);

    // A miss whose fill is being returned this cycle is already served;
    // masking it prevents a duplicate refill before the requester drops it.
    assign d_go = d_rd_miss & ~d_fill_q;
    assign i_go = i_miss & ~i_fill_q;

    always_ff @(posedge clk) begin
        if (wb_push) begin
            wb_addr_q[wr_ptr_q] <= d_wr_addr;
            wb_data_q[wr_ptr_q] <= d_wr_data;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wb_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (wb_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_data_d = fill_data_q;
        i_fill_d    = 1'b0;
        d_fill_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Stores drain ahead of a data read so it sees them.
                if (full || (d_go && !empty)) begin
                    state_d     = WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wb_addr_q[rd_ptr_q];
                    mem_wdata_d = wb_data_q[rd_ptr_q];
                end else if (d_go) begin
                    state_d    = RD_D;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = d_addr;
                end else if (i_go) begin
                    state_d    = RD_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
                end else if (!empty) begin
                    state_d     = WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wb_addr_q[rd_ptr_q];
                    mem_wdata_d = wb_data_q[rd_ptr_q];
                end
            end
            WR, RD_D, RD_I: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q != WR) fill_data_d = mem_rdata;
                    i_fill_d = (state_q == RD_I);
                    d_fill_d = (state_q == RD_D);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_data_q <= '0;
            i_fill_q    <= 1'b0;
            d_fill_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fill_data_q <= fill_data_d;
            i_fill_q    <= i_fill_d;
            d_fill_q    <= d_fill_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign fill_data    = fill_data_q;
    assign i_fill_valid = i_fill_q;
    assign d_fill_valid = d_fill_q;
    assign wb_full      = full;
    assign wb_empty     = empty;

    assign stall = (i_miss & ~i_fill_q)
                 | (d_rd_miss & ~d_fill_q)
                 | (d_wr_req & full);

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, xfer_cnt_q;
    logic        xfer_acc;

    assign xfer_acc = mem_ready & (state_q != IDLE);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (xfer_acc && (xfer_cnt_q != '1))
                xfer_cnt_q <= xfer_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign mem_xfers    = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        areset;
    logic        i_miss, d_rd_miss, d_wr_req;
    logic [31:0] i_addr, d_addr, d_wr_addr, d_wr_data;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic        i_fill_valid, d_fill_valid;
    logic        wb_full, wb_empty, stall;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] stall_cycles, mem_xfers;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .WB_DEPTH(4)) dut (
        .clk          (clk),
        .areset       (areset),
        .i_miss       (i_miss),
        .i_addr       (i_addr),
        .d_rd_miss    (d_rd_miss),
        .d_addr       (d_addr),
        .d_wr_req     (d_wr_req),
        .d_wr_addr    (d_wr_addr),
        .d_wr_data    (d_wr_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .fill_data    (fill_data),
        .i_fill_valid (i_fill_valid),
        .d_fill_valid (d_fill_valid),
        .wb_full      (wb_full),
        .wb_empty     (wb_empty),
        .stall        (stall)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .mem_xfers    (mem_xfers)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic serve(input string tag, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int wait_c);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, mem_req, 1);
        check({tag, "_we"}, mem_we, we);
        check({tag, "_addr"}, mem_addr, addr);
        if (we) check({tag, "_wdata"}, mem_wdata, wdata);
        repeat (wait_c) tick();
        check({tag, "_held"}, {mem_req, mem_addr}, {1'b1, addr});
        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ready = 1'b0;
        check({tag, "_drop"}, mem_req, 0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        d_wr_req  = 1'b1;
        d_wr_addr = a;
        d_wr_data = d;
        tick();
        d_wr_req  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b0;
        i_miss = 0; d_rd_miss = 0; d_wr_req = 0; mem_ready = 0;
        i_addr = 0; d_addr = 0; d_wr_addr = 0; d_wr_data = 0;
        mem_rdata = 0;
        @(negedge clk); @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_we_addr_wd", {mem_we, mem_addr, mem_wdata}, 0);
        check("rst_fill", {fill_data, i_fill_valid, d_fill_valid}, 0);
        check("rst_wb", {wb_full, wb_empty, stall}, 3'b010);
        areset = 1'b1;
        tick();

        // I-cache miss, memory answers 3 cycles after mem_req
        i_miss = 1'b1;
        i_addr = 32'h100;
        #1 check("imiss_stall0", stall, 1);
        tick();
        check("imiss_cmd", {mem_req, mem_we, mem_addr}, {2'b10, 32'h100});
        tick(); tick();
        check("imiss_stall_w", stall, 1);
        check("imiss_held", {mem_req, mem_addr}, {1'b1, 32'h100});
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0;
        check("imiss_fill", {i_fill_valid, d_fill_valid, fill_data},
              {2'b10, 32'hDEADBEEF});
        check("imiss_nostall", {stall, mem_req}, 0);
        i_miss = 1'b0;
        tick();
        check("imiss_pulse_end", {i_fill_valid, mem_req}, 0);
        tick();
        check("imiss_idle", mem_req, 0);

        // Four stores with memory stalled fill the buffer
        store(32'h10, 32'hA0);
        store(32'h14, 32'hA1);
        store(32'h18, 32'hA2);
        store(32'h1C, 32'hA3);
        check("wb_full4", {wb_full, wb_empty}, 2'b10);
        check("wb_wr0", {mem_req, mem_we, mem_addr, mem_wdata},
              {2'b11, 32'h10, 32'hA0});
        d_wr_req  = 1'b1;
        d_wr_addr = 32'h20;
        d_wr_data = 32'hA4;
        #1 check("st5_stall", stall, 1);
        tick();
        check("st5_stall_hold", {stall, wb_full}, 2'b11);
        mem_ready = 1'b1;
        #1 check("st5_stall_rdy", stall, 1);
        tick();
        mem_ready = 1'b0;
        check("st5_after_pop", {wb_full, stall, mem_req}, 3'b000);
        tick();
        d_wr_req = 1'b0;
        check("st5_enq_full", wb_full, 1);
        serve("wb1", 1'b1, 32'h14, 32'hA1, 32'h0, 1);
        serve("wb2", 1'b1, 32'h18, 32'hA2, 32'h0, 0);
        serve("wb3", 1'b1, 32'h1C, 32'hA3, 32'h0, 2);
        serve("wb4", 1'b1, 32'h20, 32'hA4, 32'h0, 0);
        tick(); tick();
        check("wb_drained", {wb_empty, wb_full, mem_req}, 3'b100);

        // Two stores buffered, then a data read to the same line
        store(32'h30, 32'hB0);
        store(32'h34, 32'hB1);
        d_rd_miss = 1'b1;
        d_addr    = 32'h10;
        #1 check("raw_stall", stall, 1);
        serve("raw_w0", 1'b1, 32'h30, 32'hB0, 32'h0, 1);
        serve("raw_w1", 1'b1, 32'h34, 32'hB1, 32'h0, 0);
        check("raw_empty", wb_empty, 1);
        serve("raw_rd", 1'b0, 32'h10, 32'h0, 32'h12345678, 1);
        check("raw_fill", {d_fill_valid, i_fill_valid, fill_data},
              {2'b10, 32'h12345678});
        d_rd_miss = 1'b0;
        tick();
        check("raw_done", {d_fill_valid, mem_req}, 0);

        // Simultaneous misses: data first, then instruction
        i_miss    = 1'b1;
        i_addr    = 32'h200;
        d_rd_miss = 1'b1;
        d_addr    = 32'h300;
        serve("both_d", 1'b0, 32'h300, 32'h0, 32'h11111111, 0);
        check("both_dfill", {d_fill_valid, i_fill_valid, fill_data},
              {2'b10, 32'h11111111});
        check("both_istall", stall, 1);
        d_rd_miss = 1'b0;
        serve("both_i", 1'b0, 32'h200, 32'h0, 32'h22222222, 1);
        check("both_ifill", {i_fill_valid, d_fill_valid, fill_data},
              {2'b10, 32'h22222222});
        i_miss = 1'b0;
        tick();

        // Reset in the middle of a write with two entries buffered
        store(32'h40, 32'hC0);
        store(32'h44, 32'hC1);
        check("mid_wr", {mem_req, mem_we, wb_empty}, 3'b110);
        areset = 1'b0;
        #1 check("mid_rst", {mem_req, wb_empty, wb_full}, 3'b010);
        @(negedge clk);
        areset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_quiet", {mem_req, wb_empty}, 2'b01);
        end

`ifdef MEM_ARB_PERF_CNT_EN
        check("perf_rst", {stall_cycles, mem_xfers}, 0);
        i_miss = 1'b1;
        i_addr = 32'h400;
        tick(); tick(); tick(); tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h5;
        tick();
        mem_ready = 1'b0;
        i_miss = 1'b0;
        check("perf_cnt", {stall_cycles, mem_xfers}, {32'd5, 32'd1});
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
